// File: rtl/if_stage_q.sv
// Instruction fetch stage with a small fetch queue between imem and decode.
// Requests are issued only when the queue is sure to have room for the response.
module if_stage_q #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = '0,
  parameter int               QDEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic [1:0]                  pcsource,
  input  logic [XLEN-1:0]             bpc,
  input  logic [XLEN-1:0]             jpc,
  input  logic [XLEN-1:0]             rpc,
  output logic                        imem_req,
  output logic [XLEN-1:0]             imem_addr,
  input  logic [XLEN-1:0]             imem_rdata,
  output logic                        id_valid,
  input  logic                        id_ready,
  output logic [XLEN-1:0]             PC,
  output logic [XLEN-1:0]             pc4,
  output logic [XLEN-1:0]             inst,
  output logic [$clog2(QDEPTH):0]     q_count
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } qent_t;

  qent_t           q [QDEPTH];
  qent_t           head;
  logic [XLEN-1:0] fpc, req_addr, tgt;
  logic            inflight, redir, push, pop;
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   cnt;

  assign redir = (pcsource != 2'b00);
  // Reserve a slot for the outstanding response so a push never hits a full queue.
  assign imem_req  = !clr && !redir &&
                     (({1'b0, cnt} + {{CW{1'b0}}, inflight}) < (CW+1)'(QDEPTH));
  assign imem_addr = fpc;
  assign push      = inflight && !redir;
  assign id_valid  = (cnt != '0);
  assign pop       = id_valid && id_ready;
  assign q_count   = cnt;

  always_comb begin
    tgt = bpc;
    case (pcsource)
      2'b10:   tgt = jpc;
      2'b11:   tgt = rpc;
      default: tgt = bpc;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fpc      <= RESET_PC;
      req_addr <= '0;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fpc      <= fpc + XLEN'(4);
        req_addr <= fpc;
      end
      if (redir) begin
        // Redirect flushes everything, including the response landing this cycle.
        fpc  <= tgt & {{(XLEN-2){1'b1}}, 2'b00};
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop)  rptr <= rptr + 1'b1;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (!push && pop) cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[wptr] <= '{addr: req_addr, data: imem_rdata};
  end

  assign head = q[rptr];
  assign PC   = id_valid ? head.addr : '0;
  assign pc4  = id_valid ? head.addr + XLEN'(4) : '0;
  assign inst = id_valid ? head.data : '0;
endmodule

// File: tb/tb_if_stage_q.sv
// Directed bench for if_stage_q: sequential fetch, backpressure, redirects,
// PC wrap and asynchronous clear, against hand-computed expectations.
module tb_if_stage_q;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = '0, jpc = '0, rpc = '0;
  logic        id_ready = 1'b1;

  logic        imem_req, id_valid;
  logic [31:0] imem_addr, imem_rdata, PC, pc4, inst;
  logic [2:0]  q_count;

  logic        imem_req_w, id_valid_w;
  logic [31:0] imem_addr_w, imem_rdata_w, PC_w, pc4_w, inst_w;
  logic [2:0]  q_count_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory model: data is address xor a fixed tag, returned one cycle later.
  always @(posedge clk) begin
    imem_rdata   <= imem_addr ^ 32'hA5A5_0000;
    imem_rdata_w <= imem_addr_w ^ 32'hA5A5_0000;
  end

  if_stage_q #(.XLEN(32), .RESET_PC(32'h0), .QDEPTH(4)) dut (
    .clk(clk), .clr(clr), .pcsource(pcsource), .bpc(bpc), .jpc(jpc), .rpc(rpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .PC(PC), .pc4(pc4), .inst(inst),
    .q_count(q_count));

  if_stage_q #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .QDEPTH(4)) dut_w (
    .clk(clk), .clr(clr), .pcsource(pcsource), .bpc(bpc), .jpc(jpc), .rpc(rpc),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w),
    .id_valid(id_valid_w), .id_ready(id_ready), .PC(PC_w), .pc4(pc4_w), .inst(inst_w),
    .q_count(q_count_w));

  // Leaves the bench just after the negedge that opens cycle 0 (first cycle out of clear).
  task automatic do_reset(input logic rdy);
    @(negedge clk);
    clr = 1'b1; pcsource = 2'b00; id_ready = rdy;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    clr = 1'b1; pcsource = 2'b01; bpc = 32'h500;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b exp 0", imem_req); end
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", id_valid); end
    n_cmp++; if (q_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d exp 0", q_count); end
    n_cmp++; if (PC !== 32'h0 || pc4 !== 32'h0 || inst !== 32'h0) begin n_err++; $display("FAIL rst_head: got %h/%h/%h exp 0/0/0", PC, pc4, inst); end
    @(negedge clk); #1;
    n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h exp 0", imem_addr); end
    n_cmp++; if (imem_addr_w !== 32'hFFFF_FFF8) begin n_err++; $display("FAIL rst_addr_w: got %h exp fffffff8", imem_addr_w); end
    pcsource = 2'b00;
  endtask

  task automatic test_seq;
    logic [31:0] e;
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      #1;
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*k)) begin n_err++; $display("FAIL seq_req%0d: got %b/%h exp 1/%h", k, imem_req, imem_addr, 32'(4*k)); end
      if (k >= 2) begin
        e = 32'(4*(k-2));
        n_cmp++; if (PC !== e) begin n_err++; $display("FAIL seq_pc%0d: got %h exp %h", k, PC, e); end
        n_cmp++; if (inst !== (e ^ 32'hA5A5_0000)) begin n_err++; $display("FAIL seq_inst%0d: got %h exp %h", k, inst, e ^ 32'hA5A5_0000); end
        n_cmp++; if (pc4 !== e + 32'd4) begin n_err++; $display("FAIL seq_pc4%0d: got %h exp %h", k, pc4, e + 32'd4); end
      end
      if (k >= 2 && k <= 4) begin
        e = 32'hFFFF_FFF8 + 32'(4*(k-2));
        n_cmp++; if (PC_w !== e) begin n_err++; $display("FAIL wrap_pc%0d: got %h exp %h", k, PC_w, e); end
        n_cmp++; if (pc4_w !== e + 32'd4) begin n_err++; $display("FAIL wrap_pc4%0d: got %h exp %h", k, pc4_w, e + 32'd4); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    do_reset(1'b0);
    repeat (6) @(negedge clk);
    #1;
    n_cmp++; if (q_count !== 3'd4) begin n_err++; $display("FAIL bp_count: got %0d exp 4", q_count); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL bp_req: got %b exp 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL bp_addr: got %h exp 10", imem_addr); end
    id_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (id_valid !== 1'b1 || PC !== 32'(4*k)) begin n_err++; $display("FAIL bp_pc%0d: got %b/%h exp 1/%h", k, id_valid, PC, 32'(4*k)); end
      n_cmp++; if (inst !== (32'(4*k) ^ 32'hA5A5_0000)) begin n_err++; $display("FAIL bp_inst%0d: got %h exp %h", k, inst, 32'(4*k) ^ 32'hA5A5_0000); end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_branch;
    do_reset(1'b0);
    repeat (4) @(negedge clk);
    #1;
    n_cmp++; if (q_count !== 3'd3) begin n_err++; $display("FAIL br_pre_count: got %0d exp 3", q_count); end
    pcsource = 2'b01; bpc = 32'h100;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL br_req_redir: got %b exp 0", imem_req); end
    @(negedge clk);
    pcsource = 2'b00;
    #1;
    n_cmp++; if (id_valid !== 1'b0 || q_count !== 3'd0) begin n_err++; $display("FAIL br_flush: got %b/%0d exp 0/0", id_valid, q_count); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL br_addr: got %b/%h exp 1/100", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_cmp++; if (q_count !== 3'd0) begin n_err++; $display("FAIL br_stale: got %0d exp 0", q_count); end
    @(negedge clk); #1;
    n_cmp++; if (PC !== 32'h100 || inst !== 32'hA5A5_0100) begin n_err++; $display("FAIL br_head: got %h/%h exp 100/a5a50100", PC, inst); end
    n_cmp++; if (q_count !== 3'd1) begin n_err++; $display("FAIL br_count: got %0d exp 1", q_count); end
  endtask

  task automatic test_jump;
    @(negedge clk);
    pcsource = 2'b10; jpc = 32'h203;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL jmp_req: got %b exp 0", imem_req); end
    @(negedge clk);
    pcsource = 2'b00;
    #1;
    n_cmp++; if (imem_addr !== 32'h200) begin n_err++; $display("FAIL jmp_align: got %h exp 200", imem_addr); end
    @(negedge clk);
    pcsource = 2'b11; rpc = 32'h40;
    @(negedge clk);
    pcsource = 2'b00;
    #1;
    n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL jr_addr: got %h exp 40", imem_addr); end
    @(negedge clk);
    pcsource = 2'b10; jpc = 32'h300;
    @(negedge clk);
    jpc = 32'h305;
    @(negedge clk);
    pcsource = 2'b00;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h304) begin n_err++; $display("FAIL jmp_hold: got %b/%h exp 1/304", imem_req, imem_addr); end
  endtask

  task automatic test_async_clr;
    do_reset(1'b0);
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (q_count !== 3'd2) begin n_err++; $display("FAIL ac_pre_count: got %0d exp 2", q_count); end
    #1 clr = 1'b1;
    #1;
    n_cmp++; if (id_valid !== 1'b0 || q_count !== 3'd0 || imem_req !== 1'b0) begin n_err++; $display("FAIL ac_imm: got %b/%0d/%b exp 0/0/0", id_valid, q_count, imem_req); end
    n_cmp++; if (PC !== 32'h0) begin n_err++; $display("FAIL ac_pc: got %h exp 0", PC); end
    #1 clr = 1'b0; id_ready = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL ac_drop: got %b exp 0", id_valid); end
    @(negedge clk); #1;
    n_cmp++; if (id_valid !== 1'b1 || PC !== 32'h0 || inst !== 32'hA5A5_0000) begin n_err++; $display("FAIL ac_first: got %b/%h/%h exp 1/0/a5a50000", id_valid, PC, inst); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_backpressure();
    test_branch();
    test_jump();
    test_async_clr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
